// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned multiplier: one partial-product row per cycle through a
// 3:2 carry-save row, followed by a single carry-propagate resolve cycle.
module csa_mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CNT_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy,
  output logic [CNT_W-1:0]     rows_done
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESOLVE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;         // multiplier, shifted right one bit per row
  logic [WIDTH:0]       sum_q, sum_d;
  logic [WIDTH:0]       carry_q, carry_d;
  logic [WIDTH-1:0]     lo_q, lo_d;       // retired product bits, entering at the MSB
  logic [CNT_W-1:0]     rows_q, rows_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH:0]       pp;
  logic [WIDTH:0]       s_row;
  logic [WIDTH:0]       c_row;
  logic [WIDTH-1:0]     hi;
  logic [2*WIDTH-1:0]   full;
  logic [CNT_W-1:0]     shamt;

  // 3:2 compressor row: bitwise sum and majority carry
  function automatic logic [2*WIDTH+1:0] csa_row(input logic [WIDTH:0] x,
                                                 input logic [WIDTH:0] y,
                                                 input logic [WIDTH:0] z);
    return {x ^ y ^ z, (x & y) | (x & z) | (y & z)};
  endfunction

  // Next-state, datapath and row-retirement logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    lo_d    = lo_q;
    rows_d  = rows_q;
    prod_d  = prod_q;

    // The carry weight is already one above the sum weight after a row, so
    // the next state keeps carry unshifted and shifts sum right by one.
    pp             = {1'b0, a_q & {WIDTH{b_q[0]}}};
    {s_row, c_row} = csa_row(sum_q, carry_q, pp);
    // The remaining high part is always below 2**WIDTH, so a WIDTH-bit add is exact.
    hi    = sum_q[WIDTH-1:0] + carry_q[WIDTH-1:0];
    // R retired bits sit at the top of lo_q; shift them down to weight 0.
    shamt = CNT_W'(WIDTH) - rows_q;
    full  = {hi, lo_q} >> shamt;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sum_d   = '0;
          carry_d = '0;
          lo_d    = '0;
          rows_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          sum_d   = {1'b0, s_row[WIDTH:1]};
          carry_d = c_row;
          lo_d    = {s_row[0], lo_q[WIDTH-1:1]};
          b_d     = b_q >> 1;
          rows_d  = rows_q + 1'b1;
          if ((rows_q == CNT_W'(WIDTH - 1)) ||
              (EARLY_EXIT && (b_q[WIDTH-1:1] == '0))) begin
            state_d = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          prod_d  = full;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      lo_q    <= '0;
      rows_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      lo_q    <= lo_d;
      rows_q  <= rows_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_ACCUM) || (state_q == S_RESOLVE);
  assign out_product = prod_q;
  assign rows_done   = rows_q;

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Bench for csa_mult_sequencer: instance 0 without early exit, instance 1 with.
module tb_csa_mult_sequencer;

  localparam int W     = 32;
  localparam int CW    = 6;
  localparam int LIMIT = 40;

  logic          clk;
  logic          rst;
  logic          in_valid    [2];
  logic          in_ready    [2];
  logic [W-1:0]  in_a        [2];
  logic [W-1:0]  in_b        [2];
  logic          abort       [2];
  logic          out_valid   [2];
  logic          out_ready   [2];
  logic [2*W-1:0] out_product[2];
  logic          busy        [2];
  logic [CW-1:0] rows_done   [2];

  int vectors;
  int miscompares;
  logic [2*W-1:0] last_prod [2];

  csa_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .abort(abort[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_product(out_product[0]), .busy(busy[0]), .rows_done(rows_done[0]));

  csa_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .abort(abort[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_product(out_product[1]), .busy(busy[1]), .rows_done(rows_done[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: rows processed is the bit length of b (at least 1) with early
  // exit, or the full operand width without it.
  function automatic int ref_rows(input int s, input logic [W-1:0] b);
    int r;
    if (s == 0) return W;
    r = 1;
    for (int i = 0; i < W; i++) if (b[i]) r = i + 1;
    return r;
  endfunction

  // Issue one operation on instance s and check result, latency and handshakes.
  // Called #1 after a rising edge with instance s idle.
  task automatic run_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp_prod, input int exp_rows,
                        input int stall, input bit abort_done, input bit abort_accept);
    int n;
    chk("in_ready_idle", 64'(in_ready[s]), 64'd1);
    in_valid[s]  = 1'b1;
    in_a[s]      = a;
    in_b[s]      = b;
    abort[s]     = abort_accept;
    out_ready[s] = (stall == 0);
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    abort[s]    = 1'b0;
    in_a[s]     = $urandom;
    in_b[s]     = $urandom;
    chk("busy_after_accept", 64'(busy[s]), 64'd1);
    n = 0;
    while (!out_valid[s] && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_rows + 1));
    chk("product", out_product[s], exp_prod);
    chk("rows_done", 64'(rows_done[s]), 64'(exp_rows));
    for (int k = 0; k < stall; k++) begin
      abort[s] = abort_done;
      @(posedge clk); #1;
      chk("stall_valid", 64'(out_valid[s]), 64'd1);
      chk("stall_product", out_product[s], exp_prod);
      chk("stall_in_ready", 64'(in_ready[s]), 64'd0);
    end
    abort[s]     = 1'b0;
    out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    chk("valid_drop", 64'(out_valid[s]), 64'd0);
    chk("in_ready_after", 64'(in_ready[s]), 64'd1);
    chk("product_hold", out_product[s], exp_prod);
    last_prod[s] = exp_prod;
  endtask

  typedef struct {
    int             s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             stall;
    bit             abort_done;
    logic [63:0]    prod;
    int             rows;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    bit seen;
    int s;
    logic [W-1:0] a, b;

    vectors = 0;
    miscompares = 0;
    tbl[0] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 64'hFFFFFFFE00000001, 32};
    tbl[1] = '{1, 32'd12345,    32'h5,        0, 1'b0, 64'd61725,            3};
    tbl[2] = '{1, 32'hDEADBEEF, 32'h0,        0, 1'b0, 64'd0,                1};
    tbl[3] = '{1, 32'd1000,     32'd1000,    10, 1'b1, 64'd1000000,          10};
    tbl[4] = '{1, 32'h1,        32'h80000000, 0, 1'b0, 64'h80000000,         32};
    tbl[5] = '{1, 32'hFFFFFFFF, 32'h1,        1, 1'b0, 64'hFFFFFFFF,         1};
    tbl[6] = '{0, 32'd3,        32'd7,        2, 1'b1, 64'd21,               32};
    tbl[7] = '{0, 32'h80000000, 32'h0,        0, 1'b0, 64'd0,                32};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      abort[i] = 1'b0; out_ready[i] = 1'b0; last_prod[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_product", out_product[i], 64'd0);
      chk("rst_rows", 64'(rows_done[i]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].rows,
             tbl[i].stall, tbl[i].abort_done, 1'b0);

    // Abort mid-ACCUM at rows_done == 7, then a fresh op (abort high at accept is ignored)
    in_valid[1] = 1'b1; in_a[1] = 32'h1234; in_b[1] = 32'hFFFF;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    n = 0;
    while (rows_done[1] != 7 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_rows", 64'(rows_done[1]), 64'd7);
    abort[1] = 1'b1;
    @(posedge clk); #1;
    abort[1] = 1'b0;
    chk("abort_in_ready", 64'(in_ready[1]), 64'd1);
    chk("abort_busy", 64'(busy[1]), 64'd0);
    chk("abort_rows_kept", 64'(rows_done[1]), 64'd7);
    chk("abort_product_kept", out_product[1], last_prod[1]);
    seen = 1'b0;
    repeat (LIMIT) begin
      @(posedge clk); #1;
      if (out_valid[1]) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    run_op(1, 32'd3, 32'd7, 64'd21, 3, 0, 1'b0, 1'b1);

    // Asynchronous reset pulse between edges during ACCUM
    in_valid[1] = 1'b1; in_a[1] = 32'hFFFFFFFF; in_b[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready[1]), 64'd1);
    chk("arst_busy", 64'(busy[1]), 64'd0);
    chk("arst_out_valid", 64'(out_valid[1]), 64'd0);
    chk("arst_rows", 64'(rows_done[1]), 64'd0);
    chk("arst_product", out_product[1], 64'd0);
    #1 rst = 1'b0;
    last_prod[1] = '0;
    seen = 1'b0;
    repeat (LIMIT) begin
      @(posedge clk); #1;
      if (out_valid[1] || busy[1]) seen = 1'b1;
    end
    chk("arst_no_resume", 64'(seen), 64'd0);

    // Random back-to-back operations against the arithmetic model
    for (int k = 0; k < 1000; k++) begin
      s = int'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) b = '0;
      run_op(s, a, b, 64'(a) * 64'(b), ref_rows(s, b),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
             1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
